// File: rtl/data_mem_backend.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_backend
// Purpose  : Fixed-latency main-memory model behind the data cache. It serves
//            block refills and single-word write-through stores, one at a time.
// Options  : define CRITICAL_WORD_FIRST_EN to start each refill burst at the
//            requested word and wrap within the block.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_backend #(
    parameter int    ADDR_W      = 10,
    parameter int    MEM_DEPTH   = 256,
    parameter int    BLOCK_WORDS = 4,
    parameter int    LATENCY     = 4,
    parameter string INIT_FILE   = ""
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_we,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [31:0]                    req_wdata,
    output logic                           rsp_valid,
    output logic [$clog2(BLOCK_WORDS)-1:0] rsp_word_idx,
    output logic [31:0]                    rsp_rdata,
    output logic                           rsp_last,
    output logic                           wr_done,
    output logic                           busy
);

    localparam int c_IDX_W  = $clog2(BLOCK_WORDS);
    localparam int c_MA_W   = $clog2(MEM_DEPTH);
    localparam int c_WCNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [31:0]         c_DEPTH     = 32'(MEM_DEPTH);
    localparam logic [c_IDX_W-1:0]  c_LAST_BEAT = c_IDX_W'(BLOCK_WORDS - 1);
    localparam logic [c_WCNT_W-1:0] c_WAIT_LOAD = c_WCNT_W'(LATENCY - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_WAIT    = 2'd1;
    localparam logic [1:0] c_BURST   = 2'd2;
    localparam logic [1:0] c_WCOMMIT = 2'd3;

    logic [31:0]         r_mem [0:MEM_DEPTH-1];
    logic [1:0]          r_state;
    logic [c_WCNT_W-1:0] r_wait_cnt;
    logic [c_IDX_W-1:0]  r_beat;
    logic                r_we;
    logic [c_MA_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_rsp_valid;
    logic [c_IDX_W-1:0]  r_rsp_word_idx;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_last;
    logic                r_wr_done;

    logic [c_MA_W-1:0]   w_word_addr;
    logic [c_IDX_W-1:0]  w_offset;
    logic [c_IDX_W-1:0]  w_next_beat;
    logic [c_IDX_W-1:0]  w_next_idx;
    logic [c_MA_W-1:0]   w_rd_addr;
    logic [31:0]         w_rd_data;
    logic                w_unused;

    // Byte-offset bits carry no information for a word-wide memory.
    assign w_unused    = &{1'b0, req_addr[1:0]};
    assign w_word_addr = c_MA_W'(32'(req_addr[ADDR_W-1:2]) % c_DEPTH);

`ifdef CRITICAL_WORD_FIRST_EN
    assign w_offset = r_addr[c_IDX_W-1:0];
`else
    assign w_offset = '0;
`endif

    // Beat number that the next edge will present; the first beat is loaded out of WAIT.
    assign w_next_beat = (r_state == c_BURST) ? r_beat + 1'b1 : '0;
    assign w_next_idx  = w_offset + w_next_beat;
    assign w_rd_addr   = {r_addr[c_MA_W-1:c_IDX_W], w_next_idx};
    assign w_rd_data   = r_mem[w_rd_addr];

    assign req_ready    = (r_state == c_IDLE) && !RST;
    assign busy         = (r_state != c_IDLE);
    assign rsp_valid    = r_rsp_valid;
    assign rsp_word_idx = r_rsp_word_idx;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_last     = r_rsp_last;
    assign wr_done      = r_wr_done;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state        <= c_IDLE;
            r_wait_cnt     <= '0;
            r_beat         <= '0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_word_idx <= '0;
            r_rsp_rdata    <= '0;
            r_rsp_last     <= 1'b0;
            r_wr_done      <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_we       <= req_we;
                        r_addr     <= w_word_addr;
                        r_wdata    <= req_wdata;
                        r_wait_cnt <= c_WAIT_LOAD;
                        r_state    <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        if (r_we) begin
                            r_wr_done <= 1'b1;
                            r_state   <= c_WCOMMIT;
                        end else begin
                            r_beat         <= '0;
                            r_rsp_valid    <= 1'b1;
                            r_rsp_word_idx <= w_next_idx;
                            r_rsp_rdata    <= w_rd_data;
                            r_rsp_last     <= (w_next_beat == c_LAST_BEAT);
                            r_state        <= c_BURST;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                c_BURST: begin
                    if (r_beat == c_LAST_BEAT) begin
                        r_rsp_valid    <= 1'b0;
                        r_rsp_word_idx <= '0;
                        r_rsp_rdata    <= '0;
                        r_rsp_last     <= 1'b0;
                        r_state        <= c_IDLE;
                    end else begin
                        r_beat         <= w_next_beat;
                        r_rsp_valid    <= 1'b1;
                        r_rsp_word_idx <= w_next_idx;
                        r_rsp_rdata    <= w_rd_data;
                        r_rsp_last     <= (w_next_beat == c_LAST_BEAT);
                    end
                end
                c_WCOMMIT: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Reset forces the FSM out of WCOMMIT asynchronously, so an aborted store never lands.
    always_ff @(posedge CLK) begin
        if (r_state == c_WCOMMIT) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_backend.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_backend
// Purpose  : Scoreboard bench for data_mem_backend (refills, stores, resets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_backend;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 256;
    localparam int BW     = 4;
    localparam int LAT    = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_word_idx;
    logic [31:0] rsp_rdata;
    logic        rsp_last;
    logic        wr_done;
    logic        busy;

    data_mem_backend #(
        .ADDR_W(ADDR_W), .MEM_DEPTH(DEPTH), .BLOCK_WORDS(BW), .LATENCY(LAT), .INIT_FILE("")
    ) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_word_idx(rsp_word_idx), .rsp_rdata(rsp_rdata),
        .rsp_last(rsp_last), .wr_done(wr_done), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  idx;
        logic        last;
        int          cyc;
    } beat_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    beat_t       q_rd[$];
    wr_t         q_wr[$];
    logic [31:0] model_mem [0:DEPTH-1];
    int          cyc = 0;
    int          n_total = 0;
    int          n_bad = 0;
    int          n_last = 0;
    int          n_wrdone = 0;
    int          acc_cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive a request and hold it until accepted; returns on the negedge after the accept edge.
    task automatic issue(input logic we, input logic [11:0] addr, input logic [31:0] data);
        int    n;
        int    word;
        int    base;
        int    o;
        int    idx;
        beat_t b;
        wr_t   w;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        while (!req_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check_eq("accept_in_time", 64'(req_ready), 64'd1);
        @(negedge CLK);
        acc_cyc = cyc;
        word = (int'(addr) >> 2) % DEPTH;
        if (we) begin
            w.addr = word;
            w.data = data;
            w.cyc  = acc_cyc + LAT;
            q_wr.push_back(w);
        end else begin
            base = word & ~(BW - 1);
`ifdef CRITICAL_WORD_FIRST_EN
            o = word % BW;
`else
            o = 0;
`endif
            for (int k = 0; k < BW; k++) begin
                idx    = (o + k) % BW;
                b.data = model_mem[base + idx];
                b.idx  = 2'(idx);
                b.last = (k == BW - 1);
                b.cyc  = acc_cyc + LAT + k;
                q_rd.push_back(b);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q_rd.size() != 0 || q_wr.size() != 0 || busy) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check_eq("drain_in_time", 64'(n < 100), 64'd1);
    endtask

    beat_t mb;
    wr_t   mw;
    always @(negedge CLK) begin
        if (!RST) begin
            if (rsp_valid) begin
                if (rsp_last) n_last++;
                check_eq("beat_expected", 64'(q_rd.size() > 0), 64'd1);
                if (q_rd.size() > 0) begin
                    mb = q_rd.pop_front();
                    check_eq("beat_data_idx_last", {29'd0, rsp_rdata, rsp_word_idx, rsp_last},
                             {29'd0, mb.data, mb.idx, mb.last});
                    check_eq("beat_cycle", 64'(cyc), 64'(mb.cyc));
                end
            end else begin
                check_eq("idle_outputs_zero", {29'd0, rsp_rdata, rsp_word_idx, rsp_last}, 64'd0);
            end
            if (wr_done) begin
                n_wrdone++;
                check_eq("wr_done_expected", 64'(q_wr.size() > 0), 64'd1);
                if (q_wr.size() > 0) begin
                    mw = q_wr.pop_front();
                    check_eq("wr_done_cycle", 64'(cyc), 64'(mw.cyc));
                    model_mem[mw.addr] = mw.data;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int a1;
        int wd0;
        int l0;
        int n;

        #1 RST = 1'b1;
        #1 check_eq("reset_outputs", {25'd0, rsp_valid, rsp_last, wr_done, busy, req_ready,
                                      rsp_word_idx, rsp_rdata}, 64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1 check_eq("ready_after_release", {62'd0, req_ready, busy}, 64'd2);

        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b1, 12'(i * 4), 32'(i));
            req_valid = 1'b0;
            wait_idle();
        end

        issue(1'b0, 12'h014, 32'd0);
        req_valid = 1'b0;
        wait_idle();

        issue(1'b1, 12'h020, 32'hDEADBEEF);
        req_valid = 1'b0;
        wait_idle();
        issue(1'b0, 12'h020, 32'd0);
        req_valid = 1'b0;
        wait_idle();

        // Request held through a read; a second request appears during WAIT.
        issue(1'b0, 12'h014, 32'd0);
        a1 = acc_cyc;
        issue(1'b1, 12'h000, 32'h00001234);
        check_eq("b2b_accept_cycle", 64'(acc_cyc), 64'(a1 + LAT + BW + 1));
        req_valid = 1'b0;
        wait_idle();
        issue(1'b0, 12'h000, 32'd0);
        req_valid = 1'b0;
        wait_idle();

        issue(1'b1, 12'h400, 32'hA5A5A5A5);
        req_valid = 1'b0;
        wait_idle();
        issue(1'b0, 12'h000, 32'd0);
        req_valid = 1'b0;
        wait_idle();

        // Reset during the WAIT of a store.
        wd0 = n_wrdone;
        issue(1'b1, 12'h00C, 32'h0000CAFE);
        req_valid = 1'b0;
        @(negedge CLK);
        #2 RST = 1'b1;
        #1 check_eq("rst_mid_write_outputs", {25'd0, rsp_valid, rsp_last, wr_done, busy, req_ready,
                                              rsp_word_idx, rsp_rdata}, 64'd0);
        q_rd.delete();
        q_wr.delete();
        @(negedge CLK);
        RST = 1'b0;
        #1 check_eq("ready_after_mid_rst", 64'(req_ready), 64'd1);
        repeat (8) @(negedge CLK);
        check_eq("no_wr_done_after_abort", 64'(n_wrdone), 64'(wd0));
        issue(1'b0, 12'h00C, 32'd0);
        req_valid = 1'b0;
        wait_idle();

        // Reset while beat 2 of a burst is on the outputs.
        l0 = n_last;
        issue(1'b0, 12'h014, 32'd0);
        req_valid = 1'b0;
        n = 0;
        while (cyc != acc_cyc + LAT + 2 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check_eq("reached_beat2", 64'(n < 50), 64'd1);
        #2 RST = 1'b1;
        #1 check_eq("rst_mid_burst_outputs", {25'd0, rsp_valid, rsp_last, wr_done, busy, req_ready,
                                              rsp_word_idx, rsp_rdata}, 64'd0);
        q_rd.delete();
        q_wr.delete();
        check_eq("no_last_on_truncated", 64'(n_last), 64'(l0));
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        issue(1'b0, 12'h014, 32'd0);
        req_valid = 1'b0;
        wait_idle();
        check_eq("last_after_recovery", 64'(n_last), 64'(l0 + 1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
